// File: rtl/seven_seg_mux_axil.sv
// AXI4-Lite seven-segment scanner: packed hex nibbles, dp/blank masks, programmable dwell, anti-ghost gap.
// Optional blink support is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_mux_axil #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          NUM_DIGITS         = 8,
    parameter int          SEG_ACTIVE_LOW     = 1,
    parameter int          AN_ACTIVE_LOW      = 1,
    parameter logic [15:0] DEFAULT_DIV        = 16'd49999
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [NUM_DIGITS-1:0]           an
);
    localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);
    localparam logic [7:0]  DIG_MASK  = 8'hFF >> (8 - NUM_DIGITS);
    localparam logic        SEG_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic        AN_OFF    = (AN_ACTIVE_LOW != 0);
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);
`ifdef SEVEN_SEG_BLINK_EN
    localparam logic [1:0]  CTRL_WMASK = 2'b11;
`else
    localparam logic [1:0]  CTRL_WMASK = 2'b01;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q, rd_word;
    logic        wr_fire, rd_fire, div_wr;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  dpm_q, dpm_d, blank_q, blank_d, blink_mask;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        blink_on, digit_off;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, onehot;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // The address/data beat is consumed in the cycle AWREADY/WREADY are high.
    assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = arready_q & S_AXI_ARVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_fire)           bvalid_q <= 1'b1;
            else if (S_AXI_BREADY) bvalid_q <= 1'b0;
            arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        dpm_d   = dpm_q;
        blank_d = blank_q;
        div_d   = div_q;
        div_wr  = 1'b0;
        if (wr_fire) begin
            case (S_AXI_AWADDR[3:2])
                2'd0: if (S_AXI_WSTRB[0]) ctrl_d = S_AXI_WDATA[1:0] & CTRL_WMASK;
                2'd1: begin
                    for (int b = 0; b < 4; b++)
                        if (S_AXI_WSTRB[b]) data_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                    data_d = data_d & DATA_MASK;
                end
                2'd2: begin
                    if (S_AXI_WSTRB[0]) dpm_d   = S_AXI_WDATA[7:0] & DIG_MASK;
                    if (S_AXI_WSTRB[2]) blank_d = S_AXI_WDATA[23:16] & DIG_MASK;
                end
                default: begin
                    if (S_AXI_WSTRB[0]) div_d[7:0]  = S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) div_d[15:8] = S_AXI_WDATA[15:8];
                    div_wr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            dpm_q   <= '0;
            blank_q <= '0;
            div_q   <= DEFAULT_DIV;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            dpm_q   <= dpm_d;
            blank_q <= blank_d;
            div_q   <= div_d;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    logic [7:0]  bkm_q;
    logic [23:0] bcnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bkm_q  <= '0;
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_q + 24'd1;
            if (wr_fire && S_AXI_AWADDR[3:2] == 2'd2 && S_AXI_WSTRB[1])
                bkm_q <= S_AXI_WDATA[15:8] & DIG_MASK;
        end
    end

    assign blink_mask = bkm_q;
    assign blink_on   = ctrl_q[1] & bcnt_q[23];
`else
    assign blink_mask = '0;
    assign blink_on   = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_word[1:0] = ctrl_q;
            2'd1:    rd_word = data_q;
            2'd2:    rd_word[23:0] = {blank_q, blink_mask, dpm_q};
            default: rd_word[15:0] = div_q;
        endcase
    end

    // A divider write restarts the dwell so the new rate takes effect from a clean slot.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!ctrl_q[0]) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (div_wr) begin
            cnt_d = '0;
        end else if (cnt_q >= div_q) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign onehot    = NUM_DIGITS'(1) << idx_q;
    assign digit_off = blank_q[idx_q] | (blink_on & blink_mask[idx_q]);

    // Cycle 0 of each dwell keeps every anode off while seg settles on the new digit.
    always_comb begin
        seg_d = {7{SEG_OFF}};
        dp_d  = SEG_OFF;
        an_d  = {NUM_DIGITS{AN_OFF}};
        if (ctrl_q[0]) begin
            seg_d = hex7(data_q[{idx_q, 2'b00} +: 4]) ^ {7{SEG_OFF}};
            dp_d  = dpm_q[idx_q] ^ SEG_OFF;
            if (cnt_q != 16'd0 && !digit_off)
                an_d = onehot ^ {NUM_DIGITS{AN_OFF}};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= {7{SEG_OFF}};
            dp_q  <= SEG_OFF;
            an_q  <= {NUM_DIGITS{AN_OFF}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign an            = an_q;
endmodule

// File: tb/tb_seven_seg_mux_axil.sv
// Directed bench for seven_seg_mux_axil: 4 digits, active-low pins, scoreboard queues for reads and pins.
module tb_seven_seg_mux_axil;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [31:0] wdata, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } pin_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_exp_q[$];
    string       rd_tag_q[$];
    pin_t        pin_q[$];
    pin_t        mon_p;
    logic        mon_en = 1'b0;
    string       mon_tag = "";
    logic [15:0] cur_data;
    logic [3:0]  cur_dpm, cur_blank;
    logic [6:0]  hex_t[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_seg_mux_axil #(
        .NUM_DIGITS(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .seg(seg), .dp(dp), .an(an)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return awready;
            1:       return bvalid;
            2:       return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n = 0;
        while (!pick(sel) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) chk({tag, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_for(0, "wr_awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(1, "wr_bvalid");
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        wait_for(2, {tag, "_arready"});
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_for(3, {tag, "_rvalid"});
        chk(rd_tag_q.pop_front(), rdata, rd_exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    // One dwell slot: a dark cycle followed by nlit cycles with the digit's anode on.
    task automatic push_slot(input int d, input int nlit);
        pin_t       p;
        logic [3:0] oh;
        oh = 4'b0001 << d;
        for (int i = 0; i <= nlit; i++) begin
            p.an  = (i != 0 && !cur_blank[d]) ? ~oh : 4'hF;
            p.seg = ~hex_t[cur_data[4*d +: 4]];
            p.dp  = ~cur_dpm[d];
            pin_q.push_back(p);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (pin_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk({tag, "_drain_timeout"}, 32'(n), 32'd0);
        mon_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && pin_q.size() > 0) begin
            mon_p = pin_q.pop_front();
            chk({mon_tag, "_an"}, 32'(an), 32'(mon_p.an));
            chk({mon_tag, "_seg"}, 32'(seg), 32'(mon_p.seg));
            chk({mon_tag, "_dp"}, 32'(dp), 32'(mon_p.dp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(4'h0, 32'h0000_0000, "rst_ctrl");
        axi_read(4'h4, 32'h0000_0000, "rst_data");
        axi_read(4'h8, 32'h0000_0000, "rst_dpbl");
        axi_read(4'hC, 32'h0000_C34F, "rst_div");

        axi_write(4'h4, 32'hDEAD_1234, 4'b0011);
        axi_read(4'h4, 32'h0000_1234, "data_strb");
        axi_write(4'h4, 32'hFFFF_FFFF, 4'b1111);
        axi_read(4'h4, 32'h0000_FFFF, "data_mask");
        axi_write(4'h8, 32'hFFFF_FFFF, 4'b1111);
        axi_read(4'h8, 32'h000F_000F, "dpbl_mask");
        axi_write(4'h0, 32'hFFFF_FFFF, 4'b1111);
        axi_read(4'h0, 32'h0000_0001, "ctrl_mask");
        axi_write(4'h0, 32'h0, 4'b1111);
        axi_write(4'hC, 32'h1234_5678, 4'b1111);
        axi_read(4'hC, 32'h0000_5678, "div_mask");

        // Second write presented while the first response is stalled.
        bready = 1'b0; awaddr = 4'h4; wdata = 32'h0000_00AB; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "b2b_first");
        @(posedge clk); #1;
        awaddr = 4'h8; wdata = 32'h0001_0003;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_awready_hold", 32'(awready), 32'd0);
            chk("b2b_bvalid_hold", 32'(bvalid), 32'd1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_bvalid_clr", 32'(bvalid), 32'd0);
        wait_for(0, "b2b_second");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(1, "b2b_second_b");
        @(posedge clk); #1;
        axi_read(4'h4, 32'h0000_00AB, "b2b_data");
        axi_read(4'h8, 32'h0001_0003, "b2b_dpbl");

        // Basic scan, 4-cycle dwell.
        axi_write(4'h4, 32'h0000_4321, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        axi_write(4'hC, 32'd3, 4'hF);
        cur_data = 16'h4321; cur_dpm = 4'h0; cur_blank = 4'h0; mon_tag = "scan";
        for (int d = 0; d < 5; d++) push_slot(d % 4, 3);
        axi_write(4'h0, 32'd1, 4'hF);
        mon_en = 1'b1;
        drain("scan");

        // Blank digit 2, decimal point on digit 1.
        axi_write(4'h0, 32'd0, 4'hF);
        axi_write(4'h8, 32'h0004_0002, 4'hF);
        cur_dpm = 4'h2; cur_blank = 4'h4; mon_tag = "blank";
        for (int d = 0; d < 4; d++) push_slot(d, 3);
        axi_write(4'h0, 32'd1, 4'hF);
        mon_en = 1'b1;
        drain("blank");

        // Divider rewritten to 7 on the second cycle of digit 2.
        axi_write(4'h0, 32'd0, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        cur_dpm = 4'h0; cur_blank = 4'h0; mon_tag = "divchg";
        push_slot(0, 3); push_slot(1, 3); push_slot(2, 1); push_slot(2, 7);
        push_slot(3, 7); push_slot(0, 7);
        axi_write(4'h0, 32'd1, 4'hF);
        mon_en = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        axi_write(4'hC, 32'd7, 4'hF);
        drain("divchg");

        // Zero divider: one cycle per digit, anodes never on.
        axi_write(4'h0, 32'd0, 4'hF);
        axi_write(4'hC, 32'd0, 4'hF);
        axi_write(4'h8, 32'h0000_0001, 4'hF);
        cur_dpm = 4'h1; mon_tag = "div0";
        for (int d = 0; d < 8; d++) push_slot(d % 4, 0);
        axi_write(4'h0, 32'd1, 4'hF);
        mon_en = 1'b1;
        drain("div0");

        // Reset while a read response is stalled.
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        wait_for(2, "midrd_ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_for(3, "midrd_rv");
        @(posedge clk); #1;
        chk("midrd_rvalid_hold", 32'(rvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrd_rvalid_drop", 32'(rvalid), 32'd0);
        chk("midrd_an_off", 32'(an), 32'h0000000F);
        rst = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        chk("midrd_no_resp", 32'(rvalid), 32'd0);
        axi_read(4'h0, 32'h0, "midrd_ctrl");
        axi_read(4'hC, 32'h0000_C34F, "midrd_div");
        axi_write(4'hC, 32'd1, 4'hF);
        cur_data = 16'h0000; cur_dpm = 4'h0; cur_blank = 4'h0; mon_tag = "restart";
        for (int d = 0; d < 5; d++) push_slot(d % 4, 1);
        axi_write(4'h0, 32'd1, 4'hF);
        mon_en = 1'b1;
        drain("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
